// File: rtl/button_pkg.sv
// Shared types and default timing for the front-panel button path.
// Consumed by the debounce cell, its top wrapper and the bus interface.
package button_pkg;

   localparam int NUM_BUTTONS = 4;

   typedef logic [NUM_BUTTONS-1:0] button_vec_t;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } hold_state_t;

   // Defaults assume a 50 MHz clock: 10 ms debounce, 0.5 s first repeat, 100 ms repeat.
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/button_debounce_press_if.sv
// Button bus: raw pin levels in, debounced levels and press pulses out.
interface button_debounce_press_if;
   import button_pkg::*;

   button_vec_t RAW_BUTTONS;
   button_vec_t BUTTONS;
   button_vec_t PRESS;

   modport master (output RAW_BUTTONS, input BUTTONS, input PRESS);
   modport slave  (input RAW_BUTTONS, output BUTTONS, output PRESS);

endinterface

// File: rtl/button_debounce_cell.sv
// One button channel: two-flop synchroniser, debounce counter, press pulse.
// Optional hold auto-repeat FSM is built only when HOLD_REPEAT_EN is defined.
module button_debounce_cell
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic raw,
   output logic button,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("button_debounce_cell: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
   end

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   logic             flip;
   logic             rise;
   logic             button_next;
   logic             rep_fire;

   assign flip        = (sync2 != button) && (cnt == CNT_MAX);
   assign rise        = flip && sync2;
   assign button_next = flip ? sync2 : button;

   // Synchroniser, debounce counter and registered press pulse.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         cnt    <= '0;
         button <= 1'b0;
         press  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == button) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            button <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         press <= rise || rep_fire;
      end
   end

`ifdef HOLD_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] DLY_MAX = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PER_MAX = HOLD_W'(REPEAT_PERIOD - 1);

   hold_state_t       state, state_next;
   logic [HOLD_W-1:0] hold, hold_next;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state <= IDLE;
         hold  <= '0;
      end else begin
         state <= state_next;
         hold  <= hold_next;
      end
   end

   // Follows the level being latched this edge, so no repeat fires as the button releases.
   always_comb begin
      state_next = state;
      hold_next  = hold;
      rep_fire   = 1'b0;
      if (!button_next) begin
         state_next = IDLE;
         hold_next  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise) begin
                  state_next = DELAY;
                  hold_next  = '0;
               end
            end
            DELAY: begin
               if (hold == DLY_MAX) begin
                  state_next = REPEAT;
                  hold_next  = '0;
                  rep_fire   = 1'b1;
               end else begin
                  hold_next = hold + 1'b1;
               end
            end
            REPEAT: begin
               if (hold == PER_MAX) begin
                  hold_next = '0;
                  rep_fire  = 1'b1;
               end else begin
                  hold_next = hold + 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               hold_next  = '0;
            end
         endcase
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/button_debounce_press.sv
// Debounces the four front-panel buttons and emits per-button press pulses.
// Define HOLD_REPEAT_EN to add auto-repeat PRESS pulses while a button is held.
module button_debounce_press
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input logic                     CLOCK,
   input logic                     RESET,
   button_debounce_press_if.slave  bus
);

   button_vec_t buttons_w;
   button_vec_t press_w;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
      button_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_cell (
         .CLOCK  (CLOCK),
         .RESET  (RESET),
         .raw    (bus.RAW_BUTTONS[i]),
         .button (buttons_w[i]),
         .press  (press_w[i])
      );
   end

   assign bus.BUTTONS = buttons_w;
   assign bus.PRESS   = press_w;

endmodule
